fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV32 pipeline, directly upstream of the decode stage. It owns the fetch PC and issues one word-aligned request at a time to a variable-latency instruction memory. It also hosts the IF/ID pipeline register, presenting InstrD, PCF and PCPlus4F to decode. Stall, flush and execute-stage redirects from the hazard unit are absorbed here; stale responses are discarded and a one-entry skid buffer covers decode stalls.

---
 rtl/fetch_stage_if.sv | 57 +++++
 rtl/fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles every non-clock signal of the instruction-fetch stage.
//   Hazard unit -> fetch : PCSrcE, PCTargetE, StallD, FlushD
//   Fetch -> imem        : ImemReqValid, ImemReqAddr
//   Imem -> fetch        : ImemReqReady, ImemRespValid, ImemRespData
//   Fetch -> decode      : InstrD, PCF, PCPlus4F, ValidD
// Modport master is taken by fetch_stage; modport slave by its surroundings
// (hazard unit, instruction memory, decode).
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic        ImemReqValid;
    logic [31:0] ImemReqAddr;
    logic        ImemReqReady;
    logic        ImemRespValid;
    logic [31:0] ImemRespData;
    logic [31:0] InstrD;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidD;

    modport master (
        input  PCSrcE,
        input  PCTargetE,
        input  StallD,
        input  FlushD,
        output ImemReqValid,
        output ImemReqAddr,
        input  ImemReqReady,
        input  ImemRespValid,
        input  ImemRespData,
        output InstrD,
        output PCF,
        output PCPlus4F,
        output ValidD
    );

    modport slave (
        output PCSrcE,
        output PCTargetE,
        output StallD,
        output FlushD,
        input  ImemReqValid,
        input  ImemReqAddr,
        output ImemReqReady,
        output ImemRespValid,
        output ImemRespData,
        input  InstrD,
        input  PCF,
        input  PCPlus4F,
        input  ValidD
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of a five-stage RV32 pipeline. Owns the fetch PC,
// keeps at most one request outstanding to a variable-latency instruction
// memory, discards responses made stale by a redirect, parks a response in a
// one-entry skid buffer while decode is stalled, and holds the IF/ID register.
//
// Ports
//   CLK      : clock, all state updates on the rising edge
//   RST_N    : synchronous active-low reset
//   io_fetch : fetch_stage_if.master
//              PCSrcE/PCTargetE  redirect from execute
//              StallD/FlushD     hazard-unit controls for IF/ID
//              ImemReq*/ImemResp* instruction-memory handshake
//              InstrD/PCF/PCPlus4F/ValidD  IF/ID register to decode
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           CLK,
    input logic           RST_N,
    fetch_stage_if.master io_fetch
);

    typedef enum logic [1:0] {
        StIdle,  // no request outstanding
        StWait,  // request outstanding, response wanted
        StDrop   // request outstanding, response to be thrown away
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_buf_valid;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_valid_d;
    logic [31:0] r_instr_d;
    logic [31:0] r_pcf;
    logic [31:0] r_pcplus4f;

    logic [31:0] w_fetch_pc_next;
    logic [31:0] w_req_pc_next;
    logic        w_buf_valid_next;
    logic [31:0] w_buf_instr_next;
    logic [31:0] w_buf_pc_next;
    logic        w_valid_d_next;
    logic [31:0] w_instr_d_next;
    logic [31:0] w_pcf_next;
    logic [31:0] w_pcplus4f_next;

    logic        w_live;
    logic        w_req_valid;
    logic        w_accept;

    // A response is only usable if it answers a wanted request and no redirect
    // is killing it in the same cycle.
    assign w_live = (r_state == StWait) && io_fetch.ImemRespValid && !io_fetch.PCSrcE;

    // The next request may issue in the response cycle, which is what gives
    // back-to-back throughput with a one-cycle memory. Blocking on a full
    // buffer or a stall keeps the buffer from ever needing a second entry.
    assign w_req_valid = RST_N && !r_buf_valid && !io_fetch.StallD && !io_fetch.PCSrcE &&
                         ((r_state == StIdle) ||
                          ((r_state == StWait) && io_fetch.ImemRespValid));

    assign w_accept = w_req_valid && io_fetch.ImemReqReady;

    // -------------------------------------------------------------------------
    // Request tracking FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (io_fetch.ImemRespValid) begin
                    // A same-cycle redirect discards the response; no accept
                    // can happen then, so this falls back to idle.
                    w_state_next = w_accept ? StWait : StIdle;
                end else if (io_fetch.PCSrcE) begin
                    w_state_next = StDrop;
                end
            end
            StDrop: begin
                // The stale response retires the old request whether or not a
                // new redirect arrives alongside it.
                if (io_fetch.ImemRespValid) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // PC, skid buffer and IF/ID next-state
    // -------------------------------------------------------------------------
    always_comb begin
        w_fetch_pc_next  = r_fetch_pc;
        w_req_pc_next    = r_req_pc;
        w_buf_valid_next = r_buf_valid;
        w_buf_instr_next = r_buf_instr;
        w_buf_pc_next    = r_buf_pc;
        w_valid_d_next   = r_valid_d;
        w_instr_d_next   = r_instr_d;
        w_pcf_next       = r_pcf;
        w_pcplus4f_next  = r_pcplus4f;

        // Redirect overrides the sequential increment.
        if (io_fetch.PCSrcE) begin
            w_fetch_pc_next = io_fetch.PCTargetE;
        end else if (w_accept) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
        end

        if (w_accept) begin
            w_req_pc_next = r_fetch_pc;
        end

        // Skid buffer: filled by a live response while decode is stalled,
        // drained into IF/ID once the stall lifts, dropped on a redirect.
        if (io_fetch.PCSrcE) begin
            w_buf_valid_next = 1'b0;
        end else if (io_fetch.StallD) begin
            if (w_live) begin
                w_buf_valid_next = 1'b1;
                w_buf_instr_next = io_fetch.ImemRespData;
                w_buf_pc_next    = r_req_pc;
            end
        end else if (!io_fetch.FlushD && r_buf_valid) begin
            w_buf_valid_next = 1'b0;
        end

        // IF/ID register. Flush wins even over a stall.
        if (io_fetch.FlushD) begin
            w_valid_d_next = 1'b0;
            w_instr_d_next = NOP_INSTR;
        end else if (!io_fetch.StallD) begin
            if (r_buf_valid && !io_fetch.PCSrcE) begin
                w_valid_d_next  = 1'b1;
                w_instr_d_next  = r_buf_instr;
                w_pcf_next      = r_buf_pc;
                w_pcplus4f_next = r_buf_pc + 32'd4;
            end else if (w_live) begin
                w_valid_d_next  = 1'b1;
                w_instr_d_next  = io_fetch.ImemRespData;
                w_pcf_next      = r_req_pc;
                w_pcplus4f_next = r_req_pc + 32'd4;
            end else begin
                // Bubble: PCF/PCPlus4F keep the last real load.
                w_valid_d_next = 1'b0;
                w_instr_d_next = NOP_INSTR;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= StIdle;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_buf_valid <= 1'b0;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'h0000_0000;
            r_valid_d   <= 1'b0;
            r_instr_d   <= NOP_INSTR;
            r_pcf       <= 32'h0000_0000;
            r_pcplus4f  <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_req_pc    <= w_req_pc_next;
            r_buf_valid <= w_buf_valid_next;
            r_buf_instr <= w_buf_instr_next;
            r_buf_pc    <= w_buf_pc_next;
            r_valid_d   <= w_valid_d_next;
            r_instr_d   <= w_instr_d_next;
            r_pcf       <= w_pcf_next;
            r_pcplus4f  <= w_pcplus4f_next;
        end
    end

    assign io_fetch.ImemReqValid = w_req_valid;
    assign io_fetch.ImemReqAddr  = r_fetch_pc;
    assign io_fetch.InstrD       = r_instr_d;
    assign io_fetch.PCF          = r_pcf;
    assign io_fetch.PCPlus4F     = r_pcplus4f;
    assign io_fetch.ValidD       = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int NCYC = 4000;
    localparam int NDIR = 16;          // directed cycles before random stimulus
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    fetch_stage_if bus ();

    fetch_stage dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .io_fetch(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one outstanding-request record, a one-word buffer and
    // the decode-side register, advanced once per cycle from the rules.
    bit          m_pend;     // a request is in flight
    bit          m_stale;    // ...and a redirect has made its answer unwanted
    logic [31:0] m_req_pc;
    logic [31:0] m_fpc;
    bit          m_bv;
    logic [31:0] m_bi;
    logic [31:0] m_bp;
    bit          m_v;
    logic [31:0] m_instr;
    logic [31:0] m_pcf;
    logic [31:0] m_pcp4;

    // Memory environment: answers the DUT's accepted request after lat cycles.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic model_reset();
        m_pend  = 0;
        m_stale = 0;
        m_fpc   = 32'h0;
        m_bv    = 0;
        m_v     = 0;
        m_instr = NOP;
        m_pcf   = 32'h0;
        m_pcp4  = 32'h0;
    endtask

    initial begin
        bit          exp_req;
        bit          acc;
        bit          live;
        bit          dut_acc;
        int          lat;
        logic [31:0] pc_loaded;
        logic [31:0] word_loaded;
        bit          load;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.PCSrcE        = 1'b0;
        bus.PCTargetE     = 32'h0;
        bus.StallD        = 1'b0;
        bus.FlushD        = 1'b0;
        bus.ImemReqReady  = 1'b1;
        bus.ImemRespValid = 1'b0;
        bus.ImemRespData  = 32'h0;
        mem_busy = 0;
        mem_cnt  = 0;
        mem_addr = 32'h0;
        lat      = 1;
        m_req_pc = 32'h0;
        m_bi     = 32'h0;
        m_bp     = 32'h0;
        model_reset();

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                rst_n = 1'b0;
            end else if (cyc < NDIR) begin
                rst_n = 1'b1;
                bus.StallD       = 1'b0;
                bus.FlushD       = 1'b0;
                bus.PCSrcE       = 1'b0;
                bus.ImemReqReady = 1'b1;
                lat = 1;
            end else begin
                rst_n = ($urandom_range(0, 299) != 0);
                bus.StallD       = ($urandom_range(0, 4) == 0);
                bus.PCSrcE       = ($urandom_range(0, 15) == 0);
                bus.FlushD       = bus.PCSrcE ? ($urandom_range(0, 3) != 0)
                                              : ($urandom_range(0, 19) == 0);
                bus.PCTargetE    = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
                bus.ImemReqReady = ($urandom_range(0, 3) != 0);
                lat = $urandom_range(1, 4);
            end
            bus.ImemRespValid = mem_busy && (mem_cnt == 0);
            bus.ImemRespData  = bus.ImemRespValid ? memf(mem_addr) : $urandom;
            #1;

            // Hand-computed expectations pinning reset and the first fetches.
            if (cyc == 1) begin
                check("rst_req_valid", {31'b0, bus.ImemReqValid}, 32'h0);
                check("rst_instr", bus.InstrD, 32'h0000_0013);
                check("rst_validd", {31'b0, bus.ValidD}, 32'h0);
                check("rst_pcf", bus.PCF, 32'h0);
            end
            if (cyc == 3) begin
                check("first_req_valid", {31'b0, bus.ImemReqValid}, 32'h1);
                check("first_req_addr", bus.ImemReqAddr, 32'h0);
            end
            if (cyc == 4) check("second_req_addr", bus.ImemReqAddr, 32'h4);
            if (cyc == 5) begin
                check("first_instr", bus.InstrD, 32'h0123_4567);
                check("first_pcf", bus.PCF, 32'h0);
                check("first_pcp4", bus.PCPlus4F, 32'h4);
                check("first_validd", {31'b0, bus.ValidD}, 32'h1);
            end
            if (cyc == 6) begin
                check("second_instr", bus.InstrD, 32'h79FE_A3A3);
                check("second_pcf", bus.PCF, 32'h4);
                check("second_pcp4", bus.PCPlus4F, 32'h8);
            end

            // Per-cycle model comparison.
            exp_req = rst_n && !m_bv && !bus.StallD && !bus.PCSrcE &&
                      (!m_pend || (!m_stale && bus.ImemRespValid));
            if (cyc >= 1) begin
                check("req_valid", {31'b0, bus.ImemReqValid}, {31'b0, exp_req});
                if (exp_req) check("req_addr", bus.ImemReqAddr, m_fpc);
                check("validd", {31'b0, bus.ValidD}, {31'b0, m_v});
                check("instrd", bus.InstrD, m_instr);
                check("pcf", bus.PCF, m_pcf);
                check("pcplus4f", bus.PCPlus4F, m_pcp4);
            end

            dut_acc = bus.ImemReqValid && bus.ImemReqReady;

            // Advance the model by one clock.
            acc  = exp_req && bus.ImemReqReady;
            live = m_pend && !m_stale && bus.ImemRespValid && !bus.PCSrcE;
            if (!rst_n) begin
                model_reset();
            end else begin
                load = 0;
                pc_loaded = 32'h0;
                word_loaded = NOP;
                if (bus.FlushD) begin
                    m_v = 0;
                    m_instr = NOP;
                end else if (!bus.StallD) begin
                    if (m_bv && !bus.PCSrcE) begin
                        load = 1;
                        word_loaded = m_bi;
                        pc_loaded = m_bp;
                    end else if (live) begin
                        load = 1;
                        word_loaded = bus.ImemRespData;
                        pc_loaded = m_req_pc;
                    end else begin
                        m_v = 0;
                        m_instr = NOP;
                    end
                end
                if (load) begin
                    m_v = 1;
                    m_instr = word_loaded;
                    m_pcf = pc_loaded;
                    m_pcp4 = pc_loaded + 32'd4;
                end

                if (bus.PCSrcE) begin
                    m_bv = 0;
                end else if (bus.StallD) begin
                    if (live) begin
                        m_bv = 1;
                        m_bi = bus.ImemRespData;
                        m_bp = m_req_pc;
                    end
                end else if (!bus.FlushD) begin
                    m_bv = 0;
                end

                if (m_pend && bus.ImemRespValid) m_pend = 0;
                else if (m_pend && bus.PCSrcE) m_stale = 1;
                if (acc) begin
                    m_pend = 1;
                    m_stale = 0;
                    m_req_pc = m_fpc;
                end

                if (bus.PCSrcE) m_fpc = bus.PCTargetE;
                else if (acc) m_fpc = m_fpc + 32'd4;
            end

            // Advance the memory.
            if (bus.ImemRespValid) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (dut_acc) begin
                mem_busy = 1;
                mem_addr = bus.ImemReqAddr;
                mem_cnt  = lat - 1;
            end

            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
